// File: rtl/fridge_pkg.sv
// Shared definitions for the multi-compartment fridge controller.
//   fn_e        : front-panel function codes carried on sel_fn
//   ice_state_e : ice-maker cycle phases
//   max3        : helper used to size the ice phase counter
package fridge_pkg;

  typedef enum logic [1:0] {
    FN_SETP = 2'b00,
    FN_CADD = 2'b01,
    FN_CSUB = 2'b10,
    FN_ICE  = 2'b11
  } fn_e;

  typedef enum logic [1:0] {
    ICE_IDLE,
    ICE_FILL,
    ICE_FREEZE,
    ICE_HARV
  } ice_state_e;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/fridge_ice_fsm.sv
// Timed ice-maker cycle: IDLE -> FILL -> FREEZE -> HARVEST -> IDLE.
// A single down-counter times every phase; it is loaded with (phase length - 1)
// on entry and the phase ends when it reaches zero.
//   clk, rst_n : clock, async active-low reset
//   power      : main power; low aborts any cycle to IDLE without ice_done
//   ice_en     : registered enable; sampled only in IDLE
//   ice_fill   : water valve, high during FILL
//   ice_busy   : high whenever not IDLE
//   ice_done   : one-cycle pulse in the last HARVEST cycle
module fridge_ice_fsm
  import fridge_pkg::*;
#(
  parameter int unsigned FILL_CYC   = 4,
  parameter int unsigned FREEZE_CYC = 16,
  parameter int unsigned HARV_CYC   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic power,
  input  logic ice_en,
  output logic ice_fill,
  output logic ice_busy,
  output logic ice_done
);

  localparam int unsigned MAX_CYC = max3(FILL_CYC, FREEZE_CYC, HARV_CYC);
  localparam int unsigned PW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [PW-1:0] FILL_LD   = PW'(FILL_CYC - 1);
  localparam logic [PW-1:0] FREEZE_LD = PW'(FREEZE_CYC - 1);
  localparam logic [PW-1:0] HARV_LD   = PW'(HARV_CYC - 1);

  ice_state_e     state_q, state_d;
  logic [PW-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ICE_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ice_done = 1'b0;
    ice_fill = (state_q == ICE_FILL);
    ice_busy = (state_q != ICE_IDLE);
    if (!power) begin
      state_d = ICE_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ICE_IDLE: begin
          if (ice_en) begin
            state_d = ICE_FILL;
            cnt_d   = FILL_LD;
          end
        end
        ICE_FILL: begin
          if (cnt_q == '0) begin
            state_d = ICE_FREEZE;
            cnt_d   = FREEZE_LD;
          end else begin
            cnt_d = cnt_q - PW'(1);
          end
        end
        ICE_FREEZE: begin
          if (cnt_q == '0) begin
            state_d = ICE_HARV;
            cnt_d   = HARV_LD;
          end else begin
            cnt_d = cnt_q - PW'(1);
          end
        end
        ICE_HARV: begin
          if (cnt_q == '0) begin
            state_d  = ICE_IDLE;
            ice_done = 1'b1;
          end else begin
            cnt_d = cnt_q - PW'(1);
          end
        end
        default: begin
          state_d = ICE_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fridge_ctrl_multi.sv
// Multi-compartment fridge controller.
// Each of NCH channels holds a setpoint, a saturating item counter and a
// hysteresis cooling demand; a shared ice-maker FSM runs timed cycles.
//   clk, rst_n     : clock, async active-low reset
//   power          : main enable; low ignores writes, drops cooling, aborts ice
//   sel_fn/sel_ch  : function code and target channel for a write
//   wr_en/wr_data  : write strobe and operand
//   meas_temp      : packed measured temperatures, ch k at [k*TW +: TW]
//   setpoint       : packed registered setpoints
//   capacity       : packed registered item counts
//   cap_full       : per-channel counter at maximum
//   cool_on        : per-channel cooling demand
//   ice_en         : registered ice-maker enable
//   ice_fill/busy/done : ice-maker status
module fridge_ctrl_multi
  import fridge_pkg::*;
#(
  parameter int unsigned NCH        = 2,
  parameter int unsigned TW         = 5,
  parameter int unsigned CW         = 3,
  parameter int unsigned SP_RST     = 4,
  parameter int unsigned HYST       = 1,
  parameter int unsigned FILL_CYC   = 4,
  parameter int unsigned FREEZE_CYC = 16,
  parameter int unsigned HARV_CYC   = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     power,
  input  logic [1:0]                               sel_fn,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] sel_ch,
  input  logic                                     wr_en,
  input  logic [TW-1:0]                            wr_data,
  input  logic [NCH*TW-1:0]                        meas_temp,
  output logic [NCH*TW-1:0]                        setpoint,
  output logic [NCH*CW-1:0]                        capacity,
  output logic [NCH-1:0]                           cap_full,
  output logic [NCH-1:0]                           cool_on,
  output logic                                     ice_en,
  output logic                                     ice_fill,
  output logic                                     ice_busy,
  output logic                                     ice_done
);

  localparam logic [CW-1:0] CAP_MAX = '1;

  fn_e  fn;
  logic wr_ok;
  logic ice_en_q;

  assign fn    = fn_e'(sel_fn);
  // Out-of-range channel selects drop the whole write, ice enable included.
  assign wr_ok = wr_en && power && (32'(sel_ch) < NCH);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [TW-1:0] sp_q;
    logic [CW-1:0] cap_q;
    logic          cool_q;
    logic [TW-1:0] meas;
    logic          ch_wr;
    logic [CW:0]   delta;
    logic [CW:0]   cap_sum;
    logic [TW:0]   sp_hi;
    logic [TW-1:0] sp_lo;

    assign meas    = meas_temp[k*TW +: TW];
    assign ch_wr   = wr_ok && (32'(sel_ch) == 32'(k));
    assign delta   = (CW+1)'(wr_data[1:0]);
    assign cap_sum = {1'b0, cap_q} + delta;
    // Upper threshold carries an extra bit so sp near full scale cannot wrap;
    // the lower threshold floors at zero.
    assign sp_hi   = {1'b0, sp_q} + (TW+1)'(HYST);
    assign sp_lo   = (sp_q > TW'(HYST)) ? sp_q - TW'(HYST) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sp_q   <= TW'(SP_RST);
        cap_q  <= '0;
        cool_q <= 1'b0;
      end else begin
        if (ch_wr && fn == FN_SETP) sp_q <= wr_data;
        if (ch_wr && fn == FN_CADD)
          cap_q <= (cap_sum > {1'b0, CAP_MAX}) ? CAP_MAX : cap_sum[CW-1:0];
        if (ch_wr && fn == FN_CSUB)
          cap_q <= (delta > {1'b0, cap_q}) ? '0 : cap_q - delta[CW-1:0];
        if (!power)                   cool_q <= 1'b0;
        else if ({1'b0, meas} > sp_hi) cool_q <= 1'b1;
        else if (meas < sp_lo)         cool_q <= 1'b0;
      end
    end

    assign setpoint[k*TW +: TW] = sp_q;
    assign capacity[k*CW +: CW] = cap_q;
    assign cap_full[k]          = (cap_q == CAP_MAX);
    assign cool_on[k]           = cool_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     ice_en_q <= 1'b0;
    else if (wr_ok && fn == FN_ICE) ice_en_q <= wr_data[0];
  end

  assign ice_en = ice_en_q;

  fridge_ice_fsm #(
    .FILL_CYC  (FILL_CYC),
    .FREEZE_CYC(FREEZE_CYC),
    .HARV_CYC  (HARV_CYC)
  ) u_ice (
    .clk     (clk),
    .rst_n   (rst_n),
    .power   (power),
    .ice_en  (ice_en_q),
    .ice_fill(ice_fill),
    .ice_busy(ice_busy),
    .ice_done(ice_done)
  );

endmodule

// File: tb/tb_fridge_ctrl_multi.sv
module tb_fridge_ctrl_multi;

  localparam int T_FILL   = 4;
  localparam int T_FREEZE = 16;
  localparam int T_HARV   = 2;
  localparam int T_ALL    = T_FILL + T_FREEZE + T_HARV;
  localparam int HYST     = 1;
  localparam int CAPMAX   = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        power;
  logic [1:0]  sel_fn;
  logic [0:0]  sel_ch;
  logic        wr_en;
  logic [4:0]  wr_data;
  logic [9:0]  meas_temp;
  logic [9:0]  setpoint;
  logic [5:0]  capacity;
  logic [1:0]  cap_full;
  logic [1:0]  cool_on;
  logic        ice_en, ice_fill, ice_busy, ice_done;

  // three-channel build, used for out-of-range channel selects
  logic [1:0]  sel_fn3;
  logic [1:0]  sel_ch3;
  logic        wr_en3;
  logic [4:0]  wr_data3;
  logic [14:0] meas_temp3;
  logic [14:0] setpoint3;
  logic [8:0]  capacity3;
  logic [2:0]  cap_full3;
  logic [2:0]  cool_on3;
  logic        ice_en3, ice_fill3, ice_busy3, ice_done3;

  always #5 clk = ~clk;

  fridge_ctrl_multi u_dut (
    .clk(clk), .rst_n(rst_n), .power(power), .sel_fn(sel_fn), .sel_ch(sel_ch),
    .wr_en(wr_en), .wr_data(wr_data), .meas_temp(meas_temp),
    .setpoint(setpoint), .capacity(capacity), .cap_full(cap_full), .cool_on(cool_on),
    .ice_en(ice_en), .ice_fill(ice_fill), .ice_busy(ice_busy), .ice_done(ice_done)
  );

  fridge_ctrl_multi #(.NCH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .power(power), .sel_fn(sel_fn3), .sel_ch(sel_ch3),
    .wr_en(wr_en3), .wr_data(wr_data3), .meas_temp(meas_temp3),
    .setpoint(setpoint3), .capacity(capacity3), .cap_full(cap_full3), .cool_on(cool_on3),
    .ice_en(ice_en3), .ice_fill(ice_fill3), .ice_busy(ice_busy3), .ice_done(ice_done3)
  );

  typedef struct packed {
    logic [9:0] sp;
    logic [5:0] cap;
    logic [1:0] full;
    logic [1:0] cool;
    logic       ie;
    logic       fill;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: plain integers plus an ice timeline position
  // (-1 = idle, otherwise cycles elapsed since the cycle started).
  int m_sp[2];
  int m_cap[2];
  bit m_cool[2];
  bit m_ie;
  int m_t;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sp[k] = 4; m_cap[k] = 0; m_cool[k] = 1'b0;
    end
    m_ie = 1'b0;
    m_t  = -1;
  endfunction

  function automatic void model_edge(bit pw, bit we, bit [1:0] fn, int ch, int d, int m0, int m1);
    int meas[2];
    int lo, v;
    meas[0] = m0; meas[1] = m1;
    for (int k = 0; k < 2; k++) begin
      lo = m_sp[k] - HYST;
      if (lo < 0) lo = 0;
      if (!pw)                          m_cool[k] = 1'b0;
      else if (meas[k] > m_sp[k] + HYST) m_cool[k] = 1'b1;
      else if (meas[k] < lo)             m_cool[k] = 1'b0;
    end
    if (!pw)                m_t = -1;
    else if (m_t < 0)       m_t = m_ie ? 0 : -1;
    else if (m_t == T_ALL-1) m_t = -1;
    else                    m_t = m_t + 1;
    if (pw && we && ch < 2) begin
      case (fn)
        2'd0: m_sp[ch] = d;
        2'd1: begin v = m_cap[ch] + (d % 4); m_cap[ch] = (v > CAPMAX) ? CAPMAX : v; end
        2'd2: begin v = m_cap[ch] - (d % 4); m_cap[ch] = (v < 0) ? 0 : v; end
        default: m_ie = bit'(d % 2);
      endcase
    end
  endfunction

  function automatic obs_t model_obs(bit pw);
    obs_t o;
    o.sp   = {5'(m_sp[1]), 5'(m_sp[0])};
    o.cap  = {3'(m_cap[1]), 3'(m_cap[0])};
    o.full = {m_cap[1] == CAPMAX, m_cap[0] == CAPMAX};
    o.cool = {m_cool[1], m_cool[0]};
    o.ie   = m_ie;
    o.fill = (m_t >= 0) && (m_t < T_FILL);
    o.busy = (m_t >= 0);
    o.done = (m_t == T_ALL-1) && pw;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.sp = setpoint; o.cap = capacity; o.full = cap_full; o.cool = cool_on;
    o.ie = ice_en; o.fill = ice_fill; o.busy = ice_busy; o.done = ice_done;
    return o;
  endfunction

  // Monitor: every cycle the DUT presents a post-edge state; compare it to the
  // oldest prediction.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        a = dut_obs();
        n_chk++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL scoreboard @%0t: actual=%h required=%h", $time, a, e);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit pw, input bit we, input bit [1:0] fn, input bit ch,
                      input bit [4:0] d, input bit [4:0] m0, input bit [4:0] m1);
    @(negedge clk);
    power = pw; wr_en = we; sel_fn = fn; sel_ch = ch; wr_data = d;
    meas_temp = {m1, m0};
    model_edge(pw, we, fn, int'(ch), int'(d), int'(m0), int'(m1));
    sb_q.push_back(model_obs(pw));
    @(posedge clk);
    #2;
  endtask

  initial begin
    bit       pw, we, ch;
    bit [1:0] fn;
    bit [4:0] d, m0, m1;

    rst_n = 1'b0; power = 1'b0; wr_en = 1'b0; sel_fn = 2'd0; sel_ch = 1'b0;
    wr_data = '0; meas_temp = '0;
    wr_en3 = 1'b0; sel_fn3 = 2'd0; sel_ch3 = 2'd0; wr_data3 = '0; meas_temp3 = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_setpoint", int'(setpoint), 10'h084);
    chk("reset_capacity", int'(capacity), 0);
    chk("reset_cool", int'(cool_on), 0);
    chk("reset_ice_busy", int'(ice_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // setpoint write to ch1
    step(1, 1, 2'd0, 1, 5'd20, 0, 0);
    chk("sp_ch1", int'(setpoint[9:5]), 20);
    chk("sp_ch0_kept", int'(setpoint[4:0]), 4);

    // out-of-range channel on the three-channel build, then a valid one
    wr_en3 = 1'b1; sel_ch3 = 2'd3; sel_fn3 = 2'd0; wr_data3 = 5'd9;
    step(1, 0, 2'd0, 0, 0, 0, 0);
    chk("sp3_oob_ignored", int'(setpoint3), 15'h1084);
    sel_ch3 = 2'd2;
    step(1, 0, 2'd0, 0, 0, 0, 0);
    wr_en3 = 1'b0;
    chk("sp3_ch2", int'(setpoint3[14:10]), 9);
    chk("sp3_ch0_kept", int'(setpoint3[4:0]), 4);

    // capacity saturation up and down
    step(1, 1, 2'd1, 0, 5'd3, 0, 0); chk("cap_add1", int'(capacity[2:0]), 3);
    step(1, 1, 2'd1, 0, 5'd3, 0, 0); chk("cap_add2", int'(capacity[2:0]), 6);
    step(1, 1, 2'd1, 0, 5'd3, 0, 0); chk("cap_add_sat", int'(capacity[2:0]), 7);
    chk("cap_full", int'(cap_full[0]), 1);
    step(1, 1, 2'd2, 0, 5'd3, 0, 0); chk("cap_sub1", int'(capacity[2:0]), 4);
    step(1, 1, 2'd2, 0, 5'd3, 0, 0); chk("cap_sub2", int'(capacity[2:0]), 1);
    step(1, 1, 2'd2, 0, 5'd3, 0, 0); chk("cap_sub_sat", int'(capacity[2:0]), 0);

    // hysteresis on ch0 around sp=10
    step(1, 1, 2'd0, 0, 5'd10, 0, 0);
    step(1, 0, 2'd0, 0, 0, 5'd11, 0); chk("hyst_11", int'(cool_on[0]), 0);
    step(1, 0, 2'd0, 0, 0, 5'd12, 0); chk("hyst_12", int'(cool_on[0]), 1);
    step(1, 0, 2'd0, 0, 0, 5'd10, 0); chk("hyst_10_hold", int'(cool_on[0]), 1);
    step(1, 0, 2'd0, 0, 0, 5'd8, 0);  chk("hyst_8", int'(cool_on[0]), 0);
    step(1, 1, 2'd0, 0, 5'd0, 0, 0);
    step(1, 0, 2'd0, 0, 0, 0, 0);     chk("hyst_sp0", int'(cool_on[0]), 0);

    // full ice cycle; ice_en cleared during FREEZE
    step(1, 1, 2'd3, 0, 5'd1, 0, 0);
    for (int i = 1; i <= 26; i++) begin
      if (i == 10) step(1, 1, 2'd3, 0, 5'd0, 0, 0);
      else         step(1, 0, 2'd0, 0, 0, 0, 0);
      chk("ice_fill", int'(ice_fill), int'(i <= T_FILL));
      chk("ice_done", int'(ice_done), int'(i == T_ALL));
      chk("ice_busy", int'(ice_busy), int'(i <= T_ALL));
    end

    // power loss during FREEZE
    step(1, 1, 2'd3, 0, 5'd1, 5'd20, 0);
    repeat (8) step(1, 0, 2'd0, 0, 0, 5'd20, 0);
    chk("abort_pre_busy", int'(ice_busy), 1);
    chk("abort_pre_fill", int'(ice_fill), 0);
    chk("abort_pre_cool", int'(cool_on[0]), 1);
    step(0, 0, 2'd0, 0, 0, 5'd20, 0);
    chk("abort_busy", int'(ice_busy), 0);
    chk("abort_done", int'(ice_done), 0);
    chk("abort_cool", int'(cool_on), 0);
    chk("abort_ice_en", int'(ice_en), 1);
    chk("abort_sp", int'(setpoint), (20 << 5));
    step(0, 1, 2'd0, 0, 5'd31, 5'd20, 0);
    chk("off_write_ignored", int'(setpoint[4:0]), 0);
    step(1, 0, 2'd0, 0, 0, 5'd20, 0);
    chk("restore_fill", int'(ice_fill), 1);
    chk("restore_busy", int'(ice_busy), 1);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      pw = ($urandom_range(0, 15) != 0);
      we = $urandom_range(0, 1);
      fn = 2'($urandom_range(0, 3));
      ch = 1'($urandom_range(0, 1));
      d  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) != 0) begin
        m0 = 5'($urandom_range(0, 31));
        m1 = 5'($urandom_range(0, 31));
      end else begin
        m0 = 5'(m_sp[0] + $urandom_range(0, 4) - 2);
        m1 = 5'(m_sp[1] + $urandom_range(0, 4) - 2);
      end
      step(pw, we, fn, ch, d, m0, m1);
    end

    // asynchronous reset between edges
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("areset_setpoint", int'(setpoint), 10'h084);
    chk("areset_capacity", int'(capacity), 0);
    chk("areset_ice_en", int'(ice_en), 0);
    chk("areset_busy", int'(ice_busy), 0);
    chk("areset_cool", int'(cool_on), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(1, 0, 2'd0, 0, 0, 5'd9, 5'd2);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
